// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: timer window base,
// register offsets and control/status bit positions.
package dmem_responder_pkg;

    localparam logic [31:0] TIMER_BASE_DEFAULT = 32'h1000_0000;

    localparam logic [1:0] T_COUNT = 2'd0;
    localparam logic [1:0] T_CMP   = 2'd1;
    localparam logic [1:0] T_CTRL  = 2'd2;
    localparam logic [1:0] T_STAT  = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AR   = 1;
    localparam int CTRL_IE   = 2;
    localparam int STAT_PEND = 0;

    typedef enum logic [1:0] {
        REGION_NONE,
        REGION_RAM,
        REGION_TIMER
    } region_e;

endpackage

// File: rtl/dmem_responder_timer.sv
// Interval timer: free-running COUNT with COMPARE match, optional auto-reload,
// sticky W1C pending flag and a registered interrupt output.
module dmem_timer
    import dmem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wrEn,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        intimer
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [2:0]  r_ctrl;
    logic        r_pend;
    logic        r_intimer;

    logic        w_match;
    logic        w_wrCount;
    logic        w_wrCmp;
    logic        w_wrCtrl;
    logic        w_wrStat;

    assign w_match   = r_ctrl[CTRL_EN] && (r_count == r_compare);
    assign w_wrCount = wrEn && (offset == T_COUNT);
    assign w_wrCmp   = wrEn && (offset == T_CMP);
    assign w_wrCtrl  = wrEn && (offset == T_CTRL);
    assign w_wrStat  = wrEn && (offset == T_STAT);

    // Priorities: CPU write beats reload/increment on COUNT; a new match beats W1C on PEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_compare <= '0;
            r_ctrl    <= '0;
            r_pend    <= 1'b0;
            r_intimer <= 1'b0;
        end else begin
            if (w_wrCount) begin
                r_count <= wdata;
            end else if (w_match && r_ctrl[CTRL_AR]) begin
                r_count <= '0;
            end else if (r_ctrl[CTRL_EN]) begin
                r_count <= r_count + 32'd1;
            end

            if (w_wrCmp) begin
                r_compare <= wdata;
            end

            if (w_wrCtrl) begin
                r_ctrl <= wdata[2:0];
            end

            if (w_match) begin
                r_pend <= 1'b1;
            end else if (w_wrStat && wdata[STAT_PEND]) begin
                r_pend <= 1'b0;
            end

            r_intimer <= r_pend & r_ctrl[CTRL_IE];
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            T_COUNT: rdata = r_count;
            T_CMP:   rdata = r_compare;
            T_CTRL:  rdata = {29'd0, r_ctrl};
            T_STAT:  rdata = {31'd0, r_pend};
            default: rdata = '0;
        endcase
    end

    assign intimer = r_intimer;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: word RAM with async read,
// a memory-mapped interval timer, and a bus-error pulse for unmapped accesses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          RAM_AW     = 10,
    parameter logic [31:0] TIMER_BASE = TIMER_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memCe,
    input  logic        memWr,
    input  logic [31:0] memAddr,
    input  logic [31:0] wtData,
    output logic [31:0] rdData,
    output logic        intimer,
    output logic        busErr
);

    localparam int RAM_DEPTH = 2 ** RAM_AW;

    logic [31:0]       r_ram [RAM_DEPTH];
    logic              r_busErr;

    region_e           w_region;
    logic [RAM_AW-1:0] w_ramIdx;
    logic              w_ramWr;
    logic              w_timerWr;
    logic [31:0]       w_timerRdata;
    logic              w_unused;

    assign w_ramIdx = memAddr[RAM_AW+1:2];
    assign w_unused = ^memAddr[1:0];

    // RAM takes priority should a parameterisation ever overlap the timer window.
    always_comb begin
        w_region = REGION_NONE;
        if (memAddr[31:RAM_AW+2] == '0) begin
            w_region = REGION_RAM;
        end else if (memAddr[31:4] == TIMER_BASE[31:4]) begin
            w_region = REGION_TIMER;
        end
    end

    assign w_ramWr   = !rst && memCe && memWr && (w_region == REGION_RAM);
    assign w_timerWr = !rst && memCe && memWr && (w_region == REGION_TIMER);

    always_ff @(posedge clk) begin
        if (w_ramWr) begin
            r_ram[w_ramIdx] <= wtData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busErr <= 1'b0;
        end else begin
            r_busErr <= memCe && (w_region == REGION_NONE);
        end
    end

    dmem_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .wrEn    (w_timerWr),
        .offset  (memAddr[3:2]),
        .wdata   (wtData),
        .rdata   (w_timerRdata),
        .intimer (intimer)
    );

    // Zero-wait-state read path consumed by the CPU MEM stage in the same cycle.
    always_comb begin
        rdData = '0;
        if (!rst && memCe && !memWr) begin
            case (w_region)
                REGION_RAM:   rdData = r_ram[w_ramIdx];
                REGION_TIMER: rdData = w_timerRdata;
                default:      rdData = '0;
            endcase
        end
    end

    assign busErr = r_busErr & ~rst;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: RAM, timer, collisions,
// unmapped accesses and mid-run reset.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        memCe;
    logic        memWr;
    logic [31:0] memAddr;
    logic [31:0] wtData;
    logic [31:0] rdData;
    logic        intimer;
    logic        busErr;

    int totalChecks = 0;
    int badChecks   = 0;

    localparam logic [31:0] A_COUNT = 32'h1000_0000;
    localparam logic [31:0] A_CMP   = 32'h1000_0004;
    localparam logic [31:0] A_CTRL  = 32'h1000_0008;
    localparam logic [31:0] A_STAT  = 32'h1000_000C;

    dmem_responder dut (
        .clk     (clk),
        .rst     (rst),
        .memCe   (memCe),
        .memWr   (memWr),
        .memAddr (memAddr),
        .wtData  (wtData),
        .rdData  (rdData),
        .intimer (intimer),
        .busErr  (busErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic r, input logic ce, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        rst     = r;
        memCe   = ce;
        memWr   = wr;
        memAddr = addr;
        wtData  = data;
        #1;
    endtask

    task automatic writeWord(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b0, 1'b1, 1'b1, addr, data);
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        applyStimulus(1'b0, 1'b1, 1'b0, addr, 32'd0);
        checkOutput(tag, rdData, expected);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; memCe = 1'b0; memWr = 1'b0; memAddr = '0; wtData = '0;

        applyStimulus(1'b1, 1'b1, 1'b0, A_COUNT, 32'd0);
        checkOutput("rst rdData", rdData, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("rst intimer", {31'd0, intimer}, 32'd0);
        checkOutput("rst busErr", {31'd0, busErr}, 32'd0);
        readCheck("rst count", A_COUNT, 32'd0);
        readCheck("rst ctrl", A_CTRL, 32'd0);

        $display("[TB] RAM read/write");
        writeWord(32'h0000_0010, 32'hDEAD_BEEF);
        readCheck("ram 0x10", 32'h0000_0010, 32'hDEAD_BEEF);
        readCheck("ram 0x13", 32'h0000_0013, 32'hDEAD_BEEF);
        writeWord(32'h0000_0FFC, 32'hCAFE_F00D);
        readCheck("ram last word", 32'h0000_0FFC, 32'hCAFE_F00D);
        writeWord(32'h0000_0040, 32'h55AA_55AA);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'd0);
        checkOutput("ce0 rdData", rdData, 32'd0);

        $display("[TB] unmapped accesses");
        writeWord(32'h0000_0000, 32'h1111_1111);
        writeWord(32'h2000_0000, 32'hAAAA_AAAA);
        checkOutput("busErr before", {31'd0, busErr}, 32'd0);
        idle();
        checkOutput("busErr pulse wr", {31'd0, busErr}, 32'd1);
        idle();
        checkOutput("busErr drop", {31'd0, busErr}, 32'd0);
        readCheck("ram0 intact", 32'h0000_0000, 32'h1111_1111);
        readCheck("timer intact", A_COUNT, 32'd0);
        readCheck("unmapped rd", 32'h2000_0000, 32'd0);
        idle();
        checkOutput("busErr pulse rd", {31'd0, busErr}, 32'd1);
        readCheck("past ram end", 32'h0000_1000, 32'd0);
        idle();
        checkOutput("busErr ram end", {31'd0, busErr}, 32'd1);

        $display("[TB] timer periodic");
        writeWord(A_CMP, 32'd5);
        writeWord(A_CTRL, 32'd7);
        writeWord(A_COUNT, 32'd0);
        for (int i = 0; i < 6; i++) begin
            readCheck("periodic count", A_COUNT, i);
        end
        readCheck("periodic pend", A_STAT, 32'd1);
        checkOutput("intimer lag", {31'd0, intimer}, 32'd0);
        readCheck("reload count", A_COUNT, 32'd1);
        checkOutput("intimer set", {31'd0, intimer}, 32'd1);
        writeWord(A_STAT, 32'd1);
        readCheck("w1c pend", A_STAT, 32'd0);
        idle();
        checkOutput("intimer clear", {31'd0, intimer}, 32'd0);
        writeWord(A_CTRL, 32'd0);
        writeWord(A_STAT, 32'd1);

        $display("[TB] timer wrap");
        writeWord(A_CMP, 32'd3);
        writeWord(A_COUNT, 32'hFFFF_FFFE);
        readCheck("wrap pend0", A_STAT, 32'd0);
        writeWord(A_CTRL, 32'd1);
        readCheck("wrap c0", A_COUNT, 32'hFFFF_FFFE);
        readCheck("wrap c1", A_COUNT, 32'hFFFF_FFFF);
        readCheck("wrap c2", A_COUNT, 32'd0);
        readCheck("wrap c3", A_COUNT, 32'd1);
        readCheck("wrap c4", A_COUNT, 32'd2);
        readCheck("wrap c5", A_COUNT, 32'd3);
        readCheck("wrap pend", A_STAT, 32'd1);
        readCheck("wrap continue", A_COUNT, 32'd5);
        checkOutput("wrap no irq", {31'd0, intimer}, 32'd0);

        $display("[TB] collisions");
        writeWord(A_CTRL, 32'd0);
        writeWord(A_STAT, 32'd1);
        writeWord(A_CMP, 32'd10);
        writeWord(A_COUNT, 32'd7);
        writeWord(A_CTRL, 32'd1);
        readCheck("coll c7", A_COUNT, 32'd7);
        idle();
        idle();
        writeWord(A_COUNT, 32'd100);
        readCheck("cpu wr wins", A_COUNT, 32'd100);
        readCheck("coll pend", A_STAT, 32'd1);
        writeWord(A_CTRL, 32'd0);
        writeWord(A_COUNT, 32'd7);
        writeWord(A_STAT, 32'd1);
        readCheck("coll w1c", A_STAT, 32'd0);
        writeWord(A_CTRL, 32'd1);
        readCheck("coll2 c7", A_COUNT, 32'd7);
        idle();
        idle();
        writeWord(A_STAT, 32'd1);
        readCheck("set beats w1c", A_STAT, 32'd1);
        writeWord(A_CTRL, 32'hFFFF_FFF8);
        readCheck("ctrl upper", A_CTRL, 32'd0);

        $display("[TB] reset mid-run");
        writeWord(A_STAT, 32'd1);
        writeWord(A_CMP, 32'd2);
        writeWord(A_COUNT, 32'd0);
        writeWord(A_CTRL, 32'd7);
        for (int i = 0; i < 5; i++) begin
            idle();
        end
        checkOutput("run intimer", {31'd0, intimer}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'd0);
        checkOutput("mid rst busErr", {31'd0, busErr}, 32'd0);
        idle();
        checkOutput("post rst intimer", {31'd0, intimer}, 32'd0);
        readCheck("post rst count", A_COUNT, 32'd0);
        readCheck("post rst cmp", A_CMP, 32'd0);
        readCheck("post rst ctrl", A_CTRL, 32'd0);
        readCheck("post rst stat", A_STAT, 32'd0);
        readCheck("post rst ram", 32'h0000_0040, 32'h55AA_55AA);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
